// File: rtl/jk_timer_pkg.sv
// Shared types and constants for the JK down-counter timer.
package jk_timer_pkg;

  localparam int unsigned JK_TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } jk_state_e;

endpackage

// File: rtl/jk_toggle_cell.sv
// Single JK flip-flop with clock enable and asynchronous active-high reset to 0.
module jk_toggle_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_down_timer.sv
// Loadable down-counter timer built from JK toggle cells with a one-cycle done pulse.
// Define JK_DOWN_RELOAD_EN to make DONE reload the last start value and run periodically.
module jk_down_timer
  import jk_timer_pkg::*;
#(
  parameter int unsigned WIDTH = JK_TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] load_bits;
  logic [WIDTH-1:0] cell_j, cell_k, cell_en;
  logic             do_load, do_count;
`ifdef JK_DOWN_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Bit i toggles on decrement when every lower bit is zero (borrow ripples through).
  always_comb begin
    toggle   = '0;
    low_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      low_mask  = (WIDTH'(1) << i) - WIDTH'(1);
      toggle[i] = ~|(q & low_mask);
    end
  end

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_count  = 1'b0;
    load_bits = load_value;
`ifdef JK_DOWN_RELOAD_EN
    reload_d  = reload_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          do_load = 1'b1;
          state_d = (load_value != '0) ? StRun : StDone;
`ifdef JK_DOWN_RELOAD_EN
          if (load_value != '0) reload_d = load_value;
`endif
        end
      end
      StRun: begin
        if (enable) begin
          // A zero count (only reachable via a zero reload) finishes without wrapping.
          do_count = (q != '0);
          if (q == WIDTH'(1) || q == '0) state_d = StDone;
        end
      end
      StDone: begin
`ifdef JK_DOWN_RELOAD_EN
        do_load   = 1'b1;
        load_bits = reload_q;
        state_d   = StRun;
`else
        state_d   = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    cell_j  = do_load ? load_bits  : toggle;
    cell_k  = do_load ? ~load_bits : toggle;
    cell_en = {WIDTH{do_load | do_count}};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_toggle_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (cell_j[i]),
      .k     (cell_k[i]),
      .en    (cell_en[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef JK_DOWN_RELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_jk_down_timer.sv
// Scoreboard bench for jk_down_timer; honours JK_DOWN_RELOAD_EN when defined.
module tb_jk_down_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [W+1:0] sb[$];

  // Behavioural reference: 0 idle, 1 run, 2 done.
  int           m_state;
  logic [W-1:0] m_q;
  logic [W-1:0] m_reload;

  jk_down_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_value (load_value),
    .enable     (enable),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state  = 0;
    m_q      = '0;
    m_reload = '0;
    sb.delete();
  endtask

  // Advance the model by one edge for the currently driven inputs and push the outcome.
  task automatic model_step();
    case (m_state)
      0: if (start) begin
        if (load_value != 0) begin
          m_q      = load_value;
          m_reload = load_value;
          m_state  = 1;
        end else begin
          m_q     = '0;
          m_state = 2;
        end
      end
      1: if (enable) begin
        if (m_q <= 1) begin
          m_q     = '0;
          m_state = 2;
        end else begin
          m_q = m_q - 1'b1;
        end
      end
      default: begin
`ifdef JK_DOWN_RELOAD_EN
        m_q     = m_reload;
        m_state = 1;
`else
        m_state = 0;
`endif
      end
    endcase
    sb.push_back({m_q, m_state != 0, m_state == 2});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    enable = 1'b0;
    load_value = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+1:0] exp;
    int pulses = 0;
    #2;
    checks++;
    if ({q, busy, done} !== '0)
      $display("FAIL reset_initial: got q=%0d busy=%b done=%b, want 0 0 0", q, busy, done);
    if ({q, busy, done} !== '0) errors++;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      start = (c == 0);
      load_value = 4'd7;
      enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp) begin
        errors++;
        $display("FAIL reset_load c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({q, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_async: got q=%0d busy=%b done=%b, want 0 0 0", q, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp) begin
        errors++;
        $display("FAIL reset_after c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_count();
    logic [W+1:0] exp;
    int done_cyc = -1;
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      start = (c == 0);
      load_value = 4'd4;
      enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp) begin
        errors++;
        $display("FAIL count c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    checks++;
    if (done_cyc != 4 || pulses != 1) begin
      errors++;
      $display("FAIL count_latency: got done at %0d (%0d pulses), want 4 (1)", done_cyc, pulses);
    end
  endtask

  task automatic test_enable_gap();
    logic [W+1:0] exp;
    int done_cyc = -1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      start = (c == 0);
      load_value = 4'd4;
      enable = !(c == 3 || c == 4);
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp) begin
        errors++;
        $display("FAIL gap c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (done && done_cyc < 0) done_cyc = c;
    end
    checks++;
    if (done_cyc != 6) begin
      errors++;
      $display("FAIL gap_latency: got done at %0d, want 6", done_cyc);
    end
  endtask

  task automatic test_zero_load();
    logic [W+1:0] exp;
    int pulses = 0;
    int want;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      start = (c == 0);
      load_value = 4'd0;
      enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp || q !== 4'd0) begin
        errors++;
        $display("FAIL zero c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (done) pulses++;
    end
`ifdef JK_DOWN_RELOAD_EN
    want = 2;
`else
    want = 1;
`endif
    checks++;
    if (pulses != want) begin
      errors++;
      $display("FAIL zero_pulses: got %0d, want %0d", pulses, want);
    end
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp;
    int done_cyc = -1;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      start = (c == 0 || c == 1 || c == 4 || c == 5);
      load_value = (c == 0) ? 4'd4 : 4'd9;
      enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp) begin
        errors++;
        $display("FAIL ignore c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (done && done_cyc < 0) done_cyc = c;
    end
    checks++;
    if (done_cyc != 4) begin
      errors++;
      $display("FAIL ignore_latency: got done at %0d, want 4", done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp;
    logic [W-1:0] q_c4 = '0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      start = (c == 0 || c == 3 || c == 4);
      load_value = (c == 0) ? 4'd2 : 4'd3;
      enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp) begin
        errors++;
        $display("FAIL b2b c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (c == 4) q_c4 = q;
    end
`ifndef JK_DOWN_RELOAD_EN
    checks++;
    if (q_c4 !== 4'd3) begin
      errors++;
      $display("FAIL b2b_restart: got q=%0d, want 3", q_c4);
    end
`endif
  endtask

`ifdef JK_DOWN_RELOAD_EN
  task automatic test_reload();
    logic [W+1:0] exp;
    int pulses = 0;
    int busy_low = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      load_value = 4'd3;
      enable = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if ({q, busy, done} !== exp || q !== 4'(3 - (c % 4))) begin
        errors++;
        $display("FAIL reload c%0d: got q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                 c, q, busy, done, exp[W+1:2], exp[1], exp[0]);
      end
      if (done) pulses++;
      if (!busy) busy_low++;
    end
    checks++;
    if (pulses != 3 || busy_low != 0) begin
      errors++;
      $display("FAIL reload_period: got %0d pulses busy_low=%0d, want 3 0", pulses, busy_low);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_enable_gap();
    test_zero_load();
    test_ignore_start();
    test_back_to_back();
`ifdef JK_DOWN_RELOAD_EN
    test_reload();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
